udp_tx_arbiter: RTL and testbench

Shares the single UDP transmit port of the `network` block between three packet sources: discovery reply, IQ data and wideband spectrum. It sits between the packet formatters and `network` in the `tx_clock` domain. It sequences each frame through request, payload streaming and inter-frame gap. It also flags protocol faults: request timeout, payload overrun and short frames.

---
 rtl/udp_tx_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
// Shares the network block's single UDP transmit port between discovery, IQ and wideband sources.
// Latency: request/done/error outputs registered one cycle after the deciding sample; rdreq/data are combinational from udp_tx_enable.
// Backpressure: bytes move only on udp_tx_enable; sources hold req until their done pulse, and no grant is issued while any done pulse is out.
module udp_tx_arbiter #(
    parameter int GAP_CYCLES = 12,
    parameter int TIMEOUT    = 4096
) (
    input  logic        tx_clock,
    input  logic        Tx_reset,
    input  logic        run,
    input  logic        disc_req,
    input  logic        iq_req,
    input  logic        sp_req,
    input  logic [10:0] disc_len,
    input  logic [10:0] iq_len,
    input  logic [10:0] sp_len,
    input  logic [7:0]  disc_data,
    input  logic [7:0]  iq_data,
    input  logic [7:0]  sp_data,
    output logic        disc_rdreq,
    output logic        iq_rdreq,
    output logic        sp_rdreq,
    output logic        disc_done,
    output logic        iq_done,
    output logic        sp_done,
    output logic        udp_tx_request,
    output logic [10:0] udp_tx_length,
    output logic [7:0]  udp_tx_data,
    input  logic        udp_tx_enable,
    input  logic        udp_tx_active,
    output logic [1:0]  grant,
    output logic        err_timeout,
    output logic        err_overrun,
    output logic        err_short
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, SEND, GAP} state_t;

    state_t        state_q;
    logic [1:0]    grant_q;
    logic          req_q;
    logic [10:0]   len_q;
    logic [10:0]   cnt_q;
    logic [10:0]   cnt_d;
    logic [TW-1:0] tmo_q;
    logic [GW-1:0] gap_q;
    logic          rr_sp_q;      // 1: IQ won last, wideband takes the next tie
    logic          ovr_seen_q;
    logic [2:0]    done_q;       // {sp, iq, disc}
    logic          err_tmo_q;
    logic          err_ovr_q;
    logic          err_short_q;

    logic [1:0]    win;
    logic [10:0]   win_len;
    logic [7:0]    own_data;
    logic          in_send;
    logic          xfer;
    logic          pad;

    function automatic logic [2:0] src_onehot(input logic [1:0] g);
        case (g)
            2'b01:   return 3'b001;
            2'b10:   return 3'b010;
            2'b11:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Arbitration: discovery strict priority, IQ/wideband round-robin and gated by run
    always_comb begin
        win     = 2'b00;
        win_len = 11'd0;
        if (disc_req) begin
            win = 2'b01;
        end else if (run && iq_req && sp_req) begin
            win = rr_sp_q ? 2'b11 : 2'b10;
        end else if (run && iq_req) begin
            win = 2'b10;
        end else if (run && sp_req) begin
            win = 2'b11;
        end
        case (win)
            2'b01:   win_len = disc_len;
            2'b10:   win_len = iq_len;
            2'b11:   win_len = sp_len;
            default: win_len = 11'd0;
        endcase
    end

    // Grant mux for the payload byte of the current owner
    always_comb begin
        own_data = 8'h00;
        case (grant_q)
            2'b01:   own_data = disc_data;
            2'b10:   own_data = iq_data;
            2'b11:   own_data = sp_data;
            default: own_data = 8'h00;
        endcase
    end

    assign in_send     = (state_q == SEND);
    assign xfer        = in_send && udp_tx_enable && (cnt_q < len_q);
    assign pad         = in_send && udp_tx_enable && !(cnt_q < len_q);
    assign cnt_d       = cnt_q + 11'(xfer);

    assign udp_tx_data = xfer ? own_data : 8'h00;
    assign disc_rdreq  = xfer && (grant_q == 2'b01);
    assign iq_rdreq    = xfer && (grant_q == 2'b10);
    assign sp_rdreq    = xfer && (grant_q == 2'b11);

    assign udp_tx_request = req_q;
    assign udp_tx_length  = len_q;
    assign grant          = grant_q;
    assign disc_done      = done_q[0];
    assign iq_done        = done_q[1];
    assign sp_done        = done_q[2];
    assign err_timeout    = err_tmo_q;
    assign err_overrun    = err_ovr_q;
    assign err_short      = err_short_q;

    // Frame sequencer: IDLE -> REQ -> SEND -> GAP, all outputs registered
    always_ff @(posedge tx_clock) begin
        if (Tx_reset) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            req_q       <= 1'b0;
            len_q       <= 11'd0;
            cnt_q       <= 11'd0;
            tmo_q       <= '0;
            gap_q       <= '0;
            rr_sp_q     <= 1'b0;
            ovr_seen_q  <= 1'b0;
            done_q      <= 3'b000;
            err_tmo_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
            err_short_q <= 1'b0;
        end else begin
            done_q      <= 3'b000;
            err_tmo_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
            err_short_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // a source still sees its own done this cycle, so its req is stale
                    if (win != 2'b00 && done_q == 3'b000) begin
                        if (win == 2'b10) begin
                            rr_sp_q <= 1'b1;
                        end else if (win == 2'b11) begin
                            rr_sp_q <= 1'b0;
                        end
                        if (win_len == 11'd0) begin
                            done_q <= src_onehot(win);
                        end else begin
                            grant_q    <= win;
                            len_q      <= win_len;
                            req_q      <= 1'b1;
                            cnt_q      <= 11'd0;
                            tmo_q      <= TW'(TIMEOUT - 1);
                            ovr_seen_q <= 1'b0;
                            state_q    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (udp_tx_active) begin
                        req_q   <= 1'b0;
                        state_q <= SEND;
                    end else if (tmo_q == '0) begin
                        req_q     <= 1'b0;
                        err_tmo_q <= 1'b1;
                        done_q    <= src_onehot(grant_q);
                        grant_q   <= 2'b00;
                        gap_q     <= GW'(GAP_CYCLES);
                        state_q   <= GAP;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
                end
                SEND: begin
                    cnt_q <= cnt_d;
                    if (pad && !ovr_seen_q) begin
                        ovr_seen_q <= 1'b1;
                        err_ovr_q  <= 1'b1;
                    end
                    if (!udp_tx_active) begin
                        done_q      <= src_onehot(grant_q);
                        err_short_q <= (cnt_d < len_q);
                        grant_q     <= 2'b00;
                        gap_q       <= GW'(GAP_CYCLES);
                        state_q     <= GAP;
                    end
                end
                GAP: begin
                    if (gap_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter with a frame scoreboard and a behavioural network model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// The network raises active as soon as it sees a request, then gives length+delta enables.
module tb_udp_tx_arbiter;

    localparam int GAP = 12;
    localparam int TMO = 16;
    localparam int K_NORM = 0;
    localparam int K_TMO  = 1;
    localparam int K_ZERO = 2;

    typedef struct {
        logic [1:0]  src;
        int          kind;
        logic [10:0] len;
        int          nrd;
        int          npad;
        int          novr;
        logic        shrt;
        logic        tmo;
    } exp_t;

    logic        clk = 1'b0;
    logic        Tx_reset = 1'b1;
    logic        run = 1'b0;
    logic        disc_req = 1'b0, iq_req = 1'b0, sp_req = 1'b0;
    logic [10:0] disc_len = '0, iq_len = '0, sp_len = '0;
    logic [7:0]  disc_data, iq_data, sp_data;
    logic        disc_rdreq, iq_rdreq, sp_rdreq;
    logic        disc_done, iq_done, sp_done;
    logic        udp_tx_request;
    logic [10:0] udp_tx_length;
    logic [7:0]  udp_tx_data;
    logic        udp_tx_enable = 1'b0, udp_tx_active = 1'b0;
    logic [1:0]  grant;
    logic        err_timeout, err_overrun, err_short;

    logic [7:0]  disc_ptr = 8'h00, iq_ptr = 8'h00, sp_ptr = 8'h00;

    int   n_chk = 0, n_fail = 0;
    exp_t sb[$];

    int   nst = 0, en_left = 0, net_delta = 0;
    bit   net_ignore = 1'b0, net_abort = 1'b0, mon_clear = 1'b0;

    int   sidx = 0, fall_idx = -100, last_done_idx = -1;
    logic prev_active = 1'b0, prev_req = 1'b0;
    bit   chk_gap = 1'b0;
    int   frm_nrd = 0, frm_pad = 0, frm_bad = 0, frm_ovr = 0, frm_reqlen = 0;
    logic [10:0] frm_len = '0;
    logic [1:0]  frm_grant = '0;

    always #5 clk = ~clk;

    // Show-ahead FIFO sources: each byte is a distinct pattern per source
    assign disc_data = 8'hA5 ^ disc_ptr;
    assign iq_data   = 8'h3C ^ iq_ptr;
    assign sp_data   = 8'h69 ^ sp_ptr;

    always @(posedge clk) begin
        if (disc_rdreq) disc_ptr <= disc_ptr + 8'd1;
        if (iq_rdreq)   iq_ptr   <= iq_ptr + 8'd1;
        if (sp_rdreq)   sp_ptr   <= sp_ptr + 8'd1;
    end

    udp_tx_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .tx_clock(clk), .Tx_reset(Tx_reset), .run(run),
        .disc_req(disc_req), .iq_req(iq_req), .sp_req(sp_req),
        .disc_len(disc_len), .iq_len(iq_len), .sp_len(sp_len),
        .disc_data(disc_data), .iq_data(iq_data), .sp_data(sp_data),
        .disc_rdreq(disc_rdreq), .iq_rdreq(iq_rdreq), .sp_rdreq(sp_rdreq),
        .disc_done(disc_done), .iq_done(iq_done), .sp_done(sp_done),
        .udp_tx_request(udp_tx_request), .udp_tx_length(udp_tx_length),
        .udp_tx_data(udp_tx_data), .udp_tx_enable(udp_tx_enable),
        .udp_tx_active(udp_tx_active), .grant(grant),
        .err_timeout(err_timeout), .err_overrun(err_overrun), .err_short(err_short)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] src, input int kind, input logic [10:0] len,
                                input int nrd, input int npad, input int novr,
                                input logic shrt, input logic tmo);
        exp_t e;
        e.src = src; e.kind = kind; e.len = len; e.nrd = nrd;
        e.npad = npad; e.novr = novr; e.shrt = shrt; e.tmo = tmo;
        return e;
    endfunction

    function automatic logic [2:0] src_vec(input logic [1:0] s);
        return (s == 2'b01) ? 3'b001 : (s == 2'b10) ? 3'b010 : 3'b100;
    endfunction

    task automatic clr_frame();
        frm_nrd = 0; frm_pad = 0; frm_bad = 0; frm_ovr = 0; frm_reqlen = 0;
        frm_len = '0; frm_grant = '0;
    endtask

    task automatic net_model();
        if (net_abort) begin
            udp_tx_active = 1'b0; udp_tx_enable = 1'b0; nst = 0;
        end else if (nst == 0) begin
            udp_tx_enable = 1'b0;
            if (udp_tx_request && !net_ignore) begin
                udp_tx_active = 1'b1;
                nst = 1;
                en_left = int'(udp_tx_length) + net_delta;
            end
        end else if (en_left > 0) begin
            udp_tx_enable = 1'b1;
            en_left--;
        end else begin
            udp_tx_enable = 1'b0;
            udp_tx_active = 1'b0;
            nst = 0;
        end
    endtask

    task automatic monitor();
        int nr;
        logic [7:0] exp_d;
        logic [2:0] dn;
        exp_t e;
        sidx++;
        if (mon_clear) clr_frame();
        nr = 0;
        if (disc_rdreq) nr++;
        if (iq_rdreq)   nr++;
        if (sp_rdreq)   nr++;
        if (nr > 1) begin
            frm_bad++;
        end else if (nr == 1) begin
            exp_d = disc_rdreq ? disc_data : iq_rdreq ? iq_data : sp_data;
            if ((disc_rdreq && grant != 2'b01) || (iq_rdreq && grant != 2'b10) ||
                (sp_rdreq && grant != 2'b11) || !udp_tx_enable || udp_tx_data !== exp_d)
                frm_bad++;
            frm_nrd++;
        end else if (udp_tx_data !== 8'h00) begin
            frm_bad++;
        end else if (udp_tx_enable && grant != 2'b00) begin
            frm_pad++;
        end
        if (err_overrun) frm_ovr++;
        if (udp_tx_request) frm_reqlen++;
        if (udp_tx_request && !prev_req) begin
            frm_len = udp_tx_length;
            frm_grant = grant;
            if (chk_gap && last_done_idx >= 0) chk("done_to_request", sidx - last_done_idx, GAP + 2);
        end
        if (prev_active && !udp_tx_active) fall_idx = sidx;
        dn = {sp_done, iq_done, disc_done};
        if (dn != 3'b000) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(dn), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_src", 32'(dn), 32'(src_vec(e.src)));
                chk("grant_at_done", 32'(grant), 32'd0);
                chk("rdreq_count", frm_nrd, e.nrd);
                chk("pad_count", frm_pad, e.npad);
                chk("overrun_pulses", frm_ovr, e.novr);
                chk("err_short", 32'(err_short), 32'(e.shrt));
                chk("err_timeout", 32'(err_timeout), 32'(e.tmo));
                chk("datapath_bad", frm_bad, 0);
                if (e.kind == K_ZERO) begin
                    chk("zero_len_request", frm_reqlen, 0);
                end else begin
                    chk("grant", 32'(frm_grant), 32'(e.src));
                    chk("tx_length", 32'(frm_len), 32'(e.len));
                    if (e.kind == K_TMO) begin
                        chk("timeout_req_cycles", frm_reqlen, TMO);
                    end else begin
                        chk("req_cycles", frm_reqlen, 1);
                        chk("done_align", sidx - fall_idx, 1);
                    end
                end
            end
            last_done_idx = sidx;
            clr_frame();
        end else if (err_short || err_timeout) begin
            frm_bad++;
        end
        prev_active = udp_tx_active;
        prev_req = udp_tx_request;
    endtask

    task automatic step();
        @(negedge clk);
        net_model();
        #1;
        monitor();
    endtask

    task automatic wait_sb(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && sb.size() > target; i++) step();
        chk(tag, sb.size(), target);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_request"}, 32'(udp_tx_request), 32'd0);
        chk({tag, "_length"}, 32'(udp_tx_length), 32'd0);
        chk({tag, "_data"}, 32'(udp_tx_data), 32'd0);
        chk({tag, "_rdreq"}, 32'({disc_rdreq, iq_rdreq, sp_rdreq}), 32'd0);
        chk({tag, "_done"}, 32'({disc_done, iq_done, sp_done}), 32'd0);
        chk({tag, "_err"}, 32'({err_timeout, err_overrun, err_short}), 32'd0);
    endtask

    initial begin
        int hi;
        // reset state
        for (int i = 0; i < 3; i++) step();
        chk_all_zero("reset");
        Tx_reset = 1'b0;
        step();

        // discovery priority, then IQ, then wideband (IQ wins the first tie)
        run = 1'b1;
        disc_len = 11'd60; iq_len = 11'd1024; sp_len = 11'd1024;
        sb.push_back(mk(2'b01, K_NORM, 11'd60, 60, 0, 0, 1'b0, 1'b0));
        sb.push_back(mk(2'b10, K_NORM, 11'd1024, 1024, 0, 0, 1'b0, 1'b0));
        sb.push_back(mk(2'b11, K_NORM, 11'd1024, 1024, 0, 0, 1'b0, 1'b0));
        disc_req = 1'b1; iq_req = 1'b1; sp_req = 1'b1;
        wait_sb("prio_disc", 2, 300);
        disc_req = 1'b0;
        wait_sb("prio_iq", 1, 1300);
        iq_req = 1'b0;
        wait_sb("prio_sp", 0, 1300);
        sp_req = 1'b0;

        // round-robin with both held; back-to-back spacing checked on each request
        iq_len = 11'd20; sp_len = 11'd30;
        sb.push_back(mk(2'b10, K_NORM, 11'd20, 20, 0, 0, 1'b0, 1'b0));
        sb.push_back(mk(2'b11, K_NORM, 11'd30, 30, 0, 0, 1'b0, 1'b0));
        sb.push_back(mk(2'b10, K_NORM, 11'd20, 20, 0, 0, 1'b0, 1'b0));
        sb.push_back(mk(2'b11, K_NORM, 11'd30, 30, 0, 0, 1'b0, 1'b0));
        chk_gap = 1'b1;
        iq_req = 1'b1; sp_req = 1'b1;
        wait_sb("rr_third", 1, 300);
        iq_req = 1'b0;
        wait_sb("rr_fourth", 0, 200);
        sp_req = 1'b0;
        chk_gap = 1'b0;

        // run gating: no request while run is low, then one on the next decision edge
        run = 1'b0;
        iq_len = 11'd40;
        iq_req = 1'b1;
        hi = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (udp_tx_request) hi++;
        end
        chk("run_gate_request", hi, 0);
        sb.push_back(mk(2'b10, K_NORM, 11'd40, 40, 0, 0, 1'b0, 1'b0));
        run = 1'b1;
        step();
        chk("run_rise_request", 32'(udp_tx_request), 32'd1);
        step();
        run = 1'b0;   // falling run must not abort the granted frame
        wait_sb("run_frame", 0, 200);
        iq_req = 1'b0;
        run = 1'b1;

        // request timeout
        net_ignore = 1'b1;
        iq_len = 11'd50;
        sb.push_back(mk(2'b10, K_TMO, 11'd50, 0, 0, 0, 1'b0, 1'b1));
        iq_req = 1'b1;
        wait_sb("timeout_frame", 0, 200);
        iq_req = 1'b0;
        net_ignore = 1'b0;

        // overrun: 104 enables on a 100-byte frame
        iq_len = 11'd100;
        net_delta = 4;
        sb.push_back(mk(2'b10, K_NORM, 11'd100, 100, 4, 1, 1'b0, 1'b0));
        iq_req = 1'b1;
        wait_sb("overrun_frame", 0, 300);
        iq_req = 1'b0;

        // short frame: active drops after 50 of 100 bytes
        net_delta = -50;
        sb.push_back(mk(2'b10, K_NORM, 11'd100, 50, 0, 0, 1'b1, 1'b0));
        iq_req = 1'b1;
        wait_sb("short_frame", 0, 300);
        iq_req = 1'b0;
        net_delta = 0;

        // reset mid-SEND at byte 37: outputs clear, no done
        for (int i = 0; i < 40; i++) step();
        iq_req = 1'b1;
        for (int i = 0; i < 300 && frm_nrd < 37; i++) step();
        chk("reached_byte37", frm_nrd, 37);
        Tx_reset = 1'b1; net_abort = 1'b1; mon_clear = 1'b1; iq_req = 1'b0;
        step();
        chk_all_zero("midreset");
        Tx_reset = 1'b0; net_abort = 1'b0; mon_clear = 1'b0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (disc_done || iq_done || sp_done) hi++;
        end
        chk("midreset_no_done", hi, 0);

        // zero-length discovery: done with no network request, and only once
        disc_len = 11'd0;
        sb.push_back(mk(2'b01, K_ZERO, 11'd0, 0, 0, 0, 1'b0, 1'b0));
        disc_req = 1'b1;
        wait_sb("zero_len", 0, 50);
        disc_req = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // tie after reset goes to IQ even though IQ owned the aborted frame
        iq_len = 11'd8; sp_len = 11'd8;
        sb.push_back(mk(2'b10, K_NORM, 11'd8, 8, 0, 0, 1'b0, 1'b0));
        sb.push_back(mk(2'b11, K_NORM, 11'd8, 8, 0, 0, 1'b0, 1'b0));
        iq_req = 1'b1; sp_req = 1'b1;
        wait_sb("tie_iq", 1, 200);
        iq_req = 1'b0;
        wait_sb("tie_sp", 0, 200);
        sp_req = 1'b0;
        for (int i = 0; i < GAP + 5; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
